// File: rtl/hdb3_encoder.sv
// rtl/hdb3_encoder.sv - transmit-side HDB3 line encoder (AMI with B00V/000V substitution)
//
// Converts one binary bit per valid strobe into a 2-bit ternary symbol.
// A 4-deep tag pipe delays each bit so that, when the fourth zero of a run
// arrives, the first zero of that run can still be rewritten to a B pulse
// before it leaves the pipe.
//
// Parameters:
//   P_CODE      symbol code for a +1 pulse
//   N_CODE      symbol code for a -1 pulse (zero is always 2'b00)
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-low reset
//   valid       bit strobe; bin_in sampled and pipe advances only when high
//   bin_in      binary data bit
//   hdb3_out    encoded symbol (P_CODE / N_CODE / 2'b00), registered
//   hdb3_valid  high one cycle after each valid strobe, registered

module hdb3_encoder #(
  parameter logic [1:0] P_CODE = 2'b01,
  parameter logic [1:0] N_CODE = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic       bin_in,
  output logic [1:0] hdb3_out,
  output logic       hdb3_valid
);

  typedef enum logic [1:0] {
    T_ZERO = 2'd0,
    T_ONE  = 2'd1,
    T_B    = 2'd2,
    T_V    = 2'd3
  } tag_t;

  // pipe[0] is the newest tag, pipe[3] the oldest (next to be emitted)
  tag_t       pipe [4];
  logic [1:0] zero_run;   // zeros pushed since the last ONE or V
  logic       pulse_odd;  // parity of ONE/B pulses since the last V
  logic       last_pos;   // polarity of the last emitted pulse (1 = positive)

  logic       take_v;     // this strobe completes a run of four zeros

  assign take_v = !bin_in && (zero_run == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe[0]    <= T_ZERO;
      pipe[1]    <= T_ZERO;
      pipe[2]    <= T_ZERO;
      pipe[3]    <= T_ZERO;
      zero_run   <= 2'd0;
      pulse_odd  <= 1'b0;
      last_pos   <= 1'b0;   // last pulse treated as negative, so first pulse is +1
      hdb3_out   <= 2'b00;
      hdb3_valid <= 1'b0;
    end else if (valid) begin
      hdb3_valid <= 1'b1;

      // Output stage: convert the tag leaving stage 3
      case (pipe[3])
        T_ZERO: hdb3_out <= 2'b00;
        T_ONE, T_B: begin
          hdb3_out <= last_pos ? N_CODE : P_CODE;
          last_pos <= ~last_pos;
        end
        T_V: hdb3_out <= last_pos ? P_CODE : N_CODE;
        default: hdb3_out <= 2'b00;
      endcase

      // Shift. With an even pulse count the first zero of the run (now moving
      // into stage 3) becomes B so that the V that follows violates AMI with
      // the opposite polarity of the previous V.
      pipe[3] <= (take_v && !pulse_odd) ? T_B : pipe[2];
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];

      // Input stage
      if (bin_in) begin
        pipe[0]   <= T_ONE;
        zero_run  <= 2'd0;
        pulse_odd <= ~pulse_odd;
      end else if (take_v) begin
        pipe[0]   <= T_V;
        zero_run  <= 2'd0;
        pulse_odd <= 1'b0;
      end else begin
        pipe[0]   <= T_ZERO;
        zero_run  <= zero_run + 2'd1;
      end
    end else begin
      hdb3_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hdb3_encoder.sv
// tb/tb_hdb3_encoder.sv - directed and loopback checks for hdb3_encoder

module tb_hdb3_encoder;

  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] Z = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic       bin_in = 1'b0;
  logic [1:0] hdb3_out;
  logic       hdb3_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic       bits_q [$];
  logic [1:0] exp_q  [$];

  always #5 clk = ~clk;

  hdb3_encoder #(.P_CODE(P), .N_CODE(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .bin_in     (bin_in),
    .hdb3_out   (hdb3_out),
    .hdb3_valid (hdb3_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic b);
    @(negedge clk);
    valid  = v;
    bin_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out", {30'd0, hdb3_out}, 32'd0);
    check("rst_valid", {31'd0, hdb3_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Feed bits_q, compare symbols after the 4-symbol fill against exp_q;
  // optional idle cycles after each strobe check that outputs hold.
  task automatic run_case(input string name, input bit do_rst, input int gap);
    logic [1:0] held;
    if (do_rst) do_reset();
    for (int i = 0; i < bits_q.size(); i++) begin
      step(1'b1, bits_q[i]);
      check($sformatf("%s_v%0d", name, i), {31'd0, hdb3_valid}, 32'd1);
      if (i < 4)
        check($sformatf("%s_fill%0d", name, i), {30'd0, hdb3_out}, 32'd0);
      else if (i - 4 < exp_q.size())
        check($sformatf("%s_sym%0d", name, i - 4), {30'd0, hdb3_out}, {30'd0, exp_q[i-4]});
      held = hdb3_out;
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'b1);
        check($sformatf("%s_gapv%0d", name, i), {31'd0, hdb3_valid}, 32'd0);
        check($sformatf("%s_gapo%0d", name, i), {30'd0, hdb3_out}, {30'd0, held});
      end
    end
  endtask

  initial begin
    logic       rbits [$];
    logic [1:0] rsyms [$];
    logic       dec   [$];
    int         prev_pol, pol, last_v, errs, valt, c11, zrun, zmax, nv;
    logic       b;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("por_out", {30'd0, hdb3_out}, 32'd0);
    check("por_valid", {31'd0, hdb3_valid}, 32'd0);

    // 16 zeros: B00V+, B00V-, B00V+
    bits_q = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    exp_q  = '{P,Z,Z,P, N,Z,Z,N, P,Z,Z,P};
    run_case("zeros", 1'b1, 0);

    // odd pulse count before the run: 000V
    bits_q = '{1,0,0,0,0,1,0,0,0,0};
    exp_q  = '{P,Z,Z,Z,P,N};
    run_case("odd", 1'b1, 0);

    // even pulse count before the run: B00V, B opposite the last pulse
    bits_q = '{1,1,0,0,0,0,0,0,0,0};
    exp_q  = '{P,N,P,Z,Z,P};
    run_case("even", 1'b1, 0);

    // same stream gap-free and with 3 idle cycles between strobes
    bits_q = '{1,0,1,0,0,0,0};
    exp_q  = '{P,Z,N};
    run_case("nogap", 1'b1, 0);
    run_case("gap", 1'b1, 3);

    // reset in the middle of a zero run
    bits_q = '{1,1,1,1,1,0,0};
    exp_q  = '{P,N,P};
    run_case("pre", 1'b1, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_out", {30'd0, hdb3_out}, 32'd0);
    check("mid_rst_valid", {31'd0, hdb3_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bits_q = '{1,0,0,0,0,0,0,0,0};
    exp_q  = '{P,Z,Z,Z,P};
    run_case("post", 1'b0, 0);

    // random loopback through a reference decoder
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      b = ($urandom_range(0, 2) == 0);
      rbits.push_back(b);
      step(1'b1, b);
      rsyms.push_back(hdb3_out);
    end
    valid = 1'b0;
    prev_pol = -1;
    last_v = 0;
    errs = 0; valt = 0; c11 = 0; zrun = 0; zmax = 0; nv = 0;
    for (int j = 0; j < rsyms.size(); j++) begin
      pol = (rsyms[j] == P) ? 1 : (rsyms[j] == N) ? -1 : 0;
      if (rsyms[j] == 2'b11) c11++;
      dec.push_back(pol != 0);
      if (pol == 0) begin
        if (j >= 4) zrun++;
        if (zrun > zmax) zmax = zrun;
      end else begin
        zrun = 0;
        if (pol == prev_pol) begin
          nv++;
          dec[j] = 1'b0;
          if (j >= 3) dec[j-3] = 1'b0;
          if (pol == last_v) valt++;
          last_v = pol;
        end
        prev_pol = pol;
      end
    end
    for (int j = 4; j < rsyms.size() - 4; j++)
      if (dec[j] !== rbits[j-4]) errs++;
    check("loop_errors", errs, 0);
    check("v_alternate", valt, 0);
    check("no_code11", c11, 0);
    check("max_zero_run", {31'd0, zmax <= 3}, 32'd1);
    check("v_seen", {31'd0, nv > 0}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
